// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bundle: instruction-memory read port, redirect input and the
// valid/ready instruction stream towards the datapath.
interface fetch_prefetch_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage: one-outstanding req/ack reads into a DEPTH-entry
// prefetch FIFO of {pc, word}; redirects flush the FIFO and drop in-flight data.
module fetch_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  fetch_prefetch_if.master  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DROP = 2'd2} state_e;

  state_e             state_q, state_d;
  logic [31:0]        fpc_q, fpc_d;
  logic [31:0]        drop_addr_q, drop_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [31:0]        fifo_pc_q   [DEPTH];
  logic [31:0]        fifo_pc_d   [DEPTH];
  logic [31:0]        fifo_inst_q [DEPTH];
  logic [31:0]        fifo_inst_d [DEPTH];

  logic               ack_v;
  logic               push;
  logic               pop;
  logic               flush;
  logic [CNT_W-1:0]   count_nx;
  logic [31:0]        new_pc;

  // State register and control flops
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      fpc_q       <= RESET_PC;
      drop_addr_q <= 32'h0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fpc_q       <= fpc_d;
      drop_addr_q <= drop_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // FIFO storage needs no reset: an empty head is masked to zero
  always_ff @(posedge clk) begin
    fifo_pc_q   <= fifo_pc_d;
    fifo_inst_q <= fifo_inst_d;
  end

  // Next-state, fetch PC and FIFO bookkeeping
  always_comb begin
    state_d     = state_q;
    fpc_d       = fpc_q;
    drop_addr_d = drop_addr_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    new_pc      = bus.redirect_pc & ~32'h3;
    ack_v       = bus.mem_ack && (state_q != IDLE);
    flush       = bus.redirect;
    push        = (state_q == REQ) && ack_v && !bus.redirect;
    pop         = (count_q != '0) && bus.inst_ready && !bus.redirect;
    count_nx    = count_q + CNT_W'(push) - CNT_W'(pop);

    unique case (state_q)
      IDLE: begin
        if (bus.redirect) begin
          fpc_d = new_pc;
        end else if (count_q < CNT_W'(DEPTH)) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (bus.redirect) begin
          fpc_d = new_pc;
          if (ack_v) begin
            state_d = IDLE;
          end else begin
            // The old read stays on the bus until acked, then is thrown away
            state_d     = DROP;
            drop_addr_d = fpc_q;
          end
        end else if (ack_v) begin
          fpc_d   = fpc_q + 32'd4;
          state_d = (count_nx < CNT_W'(DEPTH)) ? REQ : IDLE;
        end
      end
      DROP: begin
        if (bus.redirect) begin
          fpc_d = new_pc;
        end
        if (ack_v) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_pc_d[wr_ptr_q]   = fpc_q;
      fifo_inst_d[wr_ptr_q] = bus.mem_rdata;
    end

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      count_d  = count_nx;
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
    end
  end

  // Outputs decoded from registers only
  always_comb begin
    bus.mem_req    = 1'b0;
    bus.mem_addr   = fpc_q;
    bus.inst_valid = 1'b0;
    bus.inst       = 32'h0;
    bus.inst_pc    = 32'h0;
    if (state_q != IDLE) begin
      bus.mem_req = 1'b1;
    end
    if (state_q == DROP) begin
      bus.mem_addr = drop_addr_q;
    end
    if (count_q != '0) begin
      bus.inst_valid = 1'b1;
      bus.inst       = fifo_inst_q[rd_ptr_q];
      bus.inst_pc    = fifo_pc_q[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Bench for fetch_prefetch_unit: directed scenarios plus random traffic,
// checked by a transaction-level fetch model and an instruction scoreboard.
module tb_fetch_prefetch_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RPC   = 32'hFFFF_FFF8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fetch_prefetch_if bus();

  fetch_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          n_chk   = 0;
  int          n_pass  = 0;
  logic        started = 1'b0;

  // Reference model: expected instruction stream and next fetch address
  ent_t        q[$];
  logic [31:0] exp_pc       = RPC;
  logic        drop_pending = 1'b0;
  logic [31:0] drop_addr    = 32'h0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare outputs, then advance the model with this cycle's handshakes
  always @(negedge clk) begin
    if (started) begin
      chk("inst_valid", 32'(bus.inst_valid), 32'(q.size() != 0));
      if (!bus.inst_valid) begin
        chk("empty_inst", bus.inst, 32'h0);
        chk("empty_inst_pc", bus.inst_pc, 32'h0);
      end
      if (bus.mem_req)
        chk("mem_addr", bus.mem_addr, drop_pending ? drop_addr : exp_pc);

      if (reset) begin
        q.delete();
        exp_pc       = RPC;
        drop_pending = 1'b0;
      end else begin
        if (bus.inst_valid && bus.inst_ready && !bus.redirect && q.size() > 0) begin
          chk("inst_pc", bus.inst_pc, q[0].pc);
          chk("inst", bus.inst, q[0].ins);
          void'(q.pop_front());
        end
        if (bus.redirect) begin
          q.delete();
          if (bus.mem_req && !bus.mem_ack) begin
            if (!drop_pending) drop_addr = exp_pc;
            drop_pending = 1'b1;
          end else if (bus.mem_req && bus.mem_ack) begin
            drop_pending = 1'b0;
          end
          exp_pc = {bus.redirect_pc[31:2], 2'b00};
        end else if (bus.mem_req && bus.mem_ack) begin
          if (drop_pending) begin
            drop_pending = 1'b0;
          end else begin
            q.push_back('{pc: exp_pc, ins: bus.mem_rdata});
            exp_pc = exp_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    logic found;
    reset           = 1'b1;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'h0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.inst_ready  = 1'b0;
    step();
    started = 1'b1;
    step();
    chk("rst_mem_req", 32'(bus.mem_req), 32'h0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'h0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);

    // Streaming with acks every cycle: no bubbles, addresses wrap past 2^32
    reset          = 1'b0;
    bus.mem_ack    = 1'b1;
    bus.inst_ready = 1'b1;
    bus.mem_rdata  = $urandom;
    step();
    chk("p1_first_req", 32'(bus.mem_req), 32'h1);
    chk("p1_first_addr", bus.mem_addr, RPC);
    for (int i = 0; i < 16; i++) begin
      bus.mem_rdata = $urandom;
      step();
      chk("p1_req_stream", 32'(bus.mem_req), 32'h1);
      chk("p1_valid_stream", 32'(bus.inst_valid), 32'h1);
    end

    // Stalled consumer: FIFO fills to DEPTH, then requests stop
    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect = 1'b0;
    for (int i = 0; i < 12; i++) begin
      bus.mem_rdata = $urandom;
      step();
    end
    chk("p2_req_stops", 32'(bus.mem_req), 32'h0);
    chk("p2_fifo_depth", 32'(q.size()), 32'(DEPTH));
    chk("p2_head_pc", bus.inst_pc, 32'h0);
    bus.inst_ready = 1'b1;
    step();
    bus.inst_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      if (bus.mem_req) found = 1'b1;
      else step();
    end
    chk("p2_refill_req", 32'(found), 32'h1);
    chk("p2_refill_addr", bus.mem_addr, 32'h10);

    // Redirect while a read to 8 is pending: bus held, data dropped
    bus.inst_ready  = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (bus.mem_req && bus.mem_addr == 32'h8) found = 1'b1;
      else step();
    end
    chk("p3_reach_addr8", 32'(found), 32'h1);
    bus.mem_ack = 1'b0;
    step();
    step();
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h100;
    step();
    bus.redirect = 1'b0;
    chk("p3_flushed", 32'(bus.inst_valid), 32'h0);
    chk("p3_held_req", 32'(bus.mem_req), 32'h1);
    chk("p3_held_addr", bus.mem_addr, 32'h8);
    step();
    chk("p3_held_addr2", bus.mem_addr, 32'h8);
    bus.mem_ack = 1'b1;
    step();
    chk("p3_drop_not_pushed", 32'(bus.inst_valid), 32'h0);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (bus.mem_req) found = 1'b1;
      else step();
    end
    chk("p3_new_req", 32'(found), 32'h1);
    chk("p3_new_addr", bus.mem_addr, 32'h100);

    // Redirect coinciding with ack: data discarded, low PC bits cleared
    step();
    step();
    chk("p4_in_req", 32'(bus.mem_req), 32'h1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h403;
    step();
    bus.redirect = 1'b0;
    bus.mem_ack  = 1'b0;
    chk("p4_no_push", 32'(bus.inst_valid), 32'h0);
    chk("p4_idle", 32'(bus.mem_req), 32'h0);
    step();
    chk("p4_req", 32'(bus.mem_req), 32'h1);
    chk("p4_addr", bus.mem_addr, 32'h400);

    // Reset during DROP with a late ack the following cycle
    bus.redirect    = 1'b1;
    bus.redirect_pc = 32'h800;
    step();
    bus.redirect = 1'b0;
    chk("p6_drop_addr", bus.mem_addr, 32'h400);
    reset = 1'b1;
    step();
    reset       = 1'b0;
    bus.mem_ack = 1'b1;
    chk("p6_rst_req", 32'(bus.mem_req), 32'h0);
    chk("p6_rst_valid", 32'(bus.inst_valid), 32'h0);
    step();
    bus.mem_ack = 1'b0;
    chk("p6_req", 32'(bus.mem_req), 32'h1);
    chk("p6_addr", bus.mem_addr, RPC);
    chk("p6_late_ack_ignored", 32'(bus.inst_valid), 32'h0);
    step();
    chk("p6_still_empty", 32'(bus.inst_valid), 32'h0);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 299) == 0);
      bus.redirect    = ($urandom_range(0, 15) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                    : 32'($urandom);
      bus.inst_ready  = 1'($urandom_range(0, 1));
      bus.mem_ack     = ($urandom_range(0, 9) < 6);
      bus.mem_rdata   = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
